// File: rtl/rv_check_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv_check_pkg: shared state encoding and checkpoint entry for rv_check_sequencer.
// Rev 1.0
// ---------------------------------------------------------------------------
package rv_check_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Entry fields are sized for the widest supported configuration; instances
  // zero-extend their narrower XLEN/RW/CW values into them.
  localparam int unsigned CHK_XLEN_MAX = 64;
  localparam int unsigned CHK_RW_MAX   = 8;
  localparam int unsigned CHK_CW_MAX   = 32;

  typedef struct packed {
    logic                    valid;
    logic [CHK_CW_MAX-1:0]   cycle;
    logic [CHK_RW_MAX-1:0]   rd;
    logic [CHK_XLEN_MAX-1:0] data;
  } chk_entry_t;

endpackage
`default_nettype wire

// File: rtl/rv_shadow_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv_shadow_regfile: NREG x XLEN shadow register file, x0 hardwired to zero.
// Rev 1.0
// ---------------------------------------------------------------------------
module rv_shadow_regfile #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            clr_i,
  input  logic            we_i,
  input  logic [RW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [RW-1:0]   raddr_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (raddr_i == '0) ? '0 : regs_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/rv_check_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv_check_sequencer: core reset sequencer + write-back checkpoint checker.
// Rev 1.0 -- optional halt detection and drain under RV_CHECK_HALT_EN.
// ---------------------------------------------------------------------------
module rv_check_sequencer
  import rv_check_pkg::*;
#(
  parameter  int XLEN       = 32,
  parameter  int NREG       = 32,
  parameter  int NCHK       = 8,
  parameter  int CW         = 16,
  parameter  int RST_CYCLES = 10,
  parameter  int TIMEOUT    = 1024,
  localparam int RW         = $clog2(NREG),
  localparam int IW         = $clog2(NCHK),
  localparam int ECW        = $clog2(NCHK + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            cpu_reset,
  input  logic            wb_en,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] pc,
  input  logic            chk_wr_en,
  input  logic [IW-1:0]   chk_wr_idx,
  input  logic [CW-1:0]   chk_wr_cycle,
  input  logic [RW-1:0]   chk_wr_rd,
  input  logic [XLEN-1:0] chk_wr_data,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic            err_valid,
  output logic [IW-1:0]   err_idx,
  output logic [XLEN-1:0] err_actual,
  output logic [ECW-1:0]  err_count
);

  localparam int HCW = $clog2(RST_CYCLES + 1);

  state_e          state_q;
  logic            cpu_reset_q;
  logic [HCW-1:0]  hold_cnt_q;
  logic [CW-1:0]   run_cycle_q;
  logic [IW:0]     ptr_q;
  chk_entry_t      tbl_q [NCHK];
  logic            timeout_q;
  logic            err_valid_q;
  logic [IW-1:0]   err_idx_q;
  logic [XLEN-1:0] err_actual_q;
  logic [ECW-1:0]  err_count_q;

  logic            start_ok;
  logic [IW-1:0]   ptr_idx;
  logic [IW:0]     ptr_nxt;
  chk_entry_t      cur;
  logic            pending;
  logic            nxt_pending;
  logic            do_cmp;
  logic            more_left;
  logic            mismatch;
  logic [RW-1:0]   sh_raddr;
  logic [XLEN-1:0] sh_rdata;
  logic [XLEN-1:0] cmp_val;

  assign start_ok    = start && !reset && ((state_q == IDLE) || (state_q == DONE));
  assign ptr_idx     = ptr_q[IW-1:0];
  assign ptr_nxt     = ptr_q + (IW+1)'(1);
  assign cur         = tbl_q[ptr_idx];
  assign pending     = (ptr_q < (IW+1)'(NCHK)) && cur.valid;
  assign nxt_pending = (ptr_nxt < (IW+1)'(NCHK)) && tbl_q[ptr_nxt[IW-1:0]].valid;

  // DRAIN ignores the cycle field: everything still pending is compared back to back.
  assign do_cmp    = ((state_q == RUN) && pending && (CHK_CW_MAX'(run_cycle_q) >= cur.cycle))
                  || ((state_q == DRAIN) && pending);
  assign more_left = do_cmp ? nxt_pending : pending;

  assign sh_raddr = cur.rd[RW-1:0];
  assign cmp_val  = (int'(cur.rd) < NREG) ? sh_rdata : '0;
  assign mismatch = do_cmp && (CHK_XLEN_MAX'(cmp_val) != cur.data);

  rv_shadow_regfile #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_shadow (
    .clk     (clk),
    .clr_i   (start_ok),
    .we_i    ((state_q == RUN) && wb_en),
    .waddr_i (wb_rd),
    .wdata_i (wb_data),
    .raddr_i (sh_raddr),
    .rdata_o (sh_rdata)
  );

`ifdef RV_CHECK_HALT_EN
  logic [XLEN-1:0] pc_prev_q;
  logic            pc_seen_q;
  logic            halt;
  // A jump-to-self shows up as the same pc in two consecutive RUN cycles.
  assign halt = pc_seen_q && (pc == pc_prev_q);
`else
  logic pc_unused;
  assign pc_unused = ^pc;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cpu_reset_q  <= 1'b1;
      hold_cnt_q   <= '0;
      run_cycle_q  <= '0;
      ptr_q        <= '0;
      timeout_q    <= 1'b0;
      err_valid_q  <= 1'b0;
      err_idx_q    <= '0;
      err_actual_q <= '0;
      err_count_q  <= '0;
      for (int i = 0; i < NCHK; i++) tbl_q[i].valid <= 1'b0;
`ifdef RV_CHECK_HALT_EN
      pc_prev_q    <= '0;
      pc_seen_q    <= 1'b0;
`endif
    end else begin
      err_valid_q <= 1'b0;

      if (chk_wr_en && !busy && (int'(chk_wr_idx) < NCHK)) begin
        tbl_q[chk_wr_idx] <= '{valid: 1'b1,
                               cycle: CHK_CW_MAX'(chk_wr_cycle),
                               rd:    CHK_RW_MAX'(chk_wr_rd),
                               data:  CHK_XLEN_MAX'(chk_wr_data)};
      end

      if (mismatch) begin
        err_valid_q  <= 1'b1;
        err_idx_q    <= ptr_idx;
        err_actual_q <= cmp_val;
        err_count_q  <= err_count_q + ECW'(1);
      end
      if (do_cmp) ptr_q <= ptr_nxt;

      case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            state_q     <= HOLD;
            cpu_reset_q <= 1'b1;
            hold_cnt_q  <= '0;
            run_cycle_q <= '0;
            ptr_q       <= '0;
            err_count_q <= '0;
            timeout_q   <= 1'b0;
`ifdef RV_CHECK_HALT_EN
            pc_seen_q   <= 1'b0;
`endif
          end
        end
        HOLD: begin
          if (hold_cnt_q == HCW'(RST_CYCLES - 1)) begin
            state_q     <= RUN;
            cpu_reset_q <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HCW'(1);
          end
        end
        RUN: begin
          run_cycle_q <= run_cycle_q + CW'(1);
`ifdef RV_CHECK_HALT_EN
          pc_prev_q   <= pc;
          pc_seen_q   <= 1'b1;
`endif
          if (!more_left) begin
            state_q <= DONE;
          end else if (run_cycle_q == CW'(TIMEOUT - 1)) begin
            state_q   <= DONE;
            timeout_q <= 1'b1;
          end
`ifdef RV_CHECK_HALT_EN
          else if (halt) begin
            state_q <= DRAIN;
          end
`endif
        end
        DRAIN: begin
          if (!more_left) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_reset  = cpu_reset_q;
  assign busy       = (state_q == HOLD) || (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign timeout    = timeout_q;
  assign pass       = done && (err_count_q == '0) && !timeout_q;
  assign err_valid  = err_valid_q;
  assign err_idx    = err_idx_q;
  assign err_actual = err_actual_q;
  assign err_count  = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_check_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rv_check_sequencer: directed table, hand sequences and random runs vs model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rv_check_sequencer;

  localparam int TO = 64;
  localparam int RC = 10;
  localparam int TL = 100;

  logic        clk = 1'b0;
  logic        reset, start, cpu_reset;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, pc;
  logic        chk_wr_en;
  logic [2:0]  chk_wr_idx;
  logic [15:0] chk_wr_cycle;
  logic [4:0]  chk_wr_rd;
  logic [31:0] chk_wr_data;
  logic        busy, done, pass, timeout, err_valid;
  logic [2:0]  err_idx;
  logic [31:0] err_actual;
  logic [3:0]  err_count;

  rv_check_sequencer #(.TIMEOUT(TO), .RST_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .start(start), .cpu_reset(cpu_reset),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .pc(pc),
    .chk_wr_en(chk_wr_en), .chk_wr_idx(chk_wr_idx), .chk_wr_cycle(chk_wr_cycle),
    .chk_wr_rd(chk_wr_rd), .chk_wr_data(chk_wr_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_valid(err_valid), .err_idx(err_idx), .err_actual(err_actual), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // current run: checkpoint table and core write-back trace
  int          e_n;
  int          e_cyc [8];
  int          e_rd  [8];
  logic [31:0] e_dat [8];
  logic        tr_en [TL];
  logic [4:0]  tr_rd [TL];
  logic [31:0] tr_dat[TL];
  logic [31:0] tr_pc [TL];
  int          inj_idx, inj_cyc, inj_rd;
  logic [31:0] inj_dat;

  int          obs_done_t;
  int          obs_idx[$];
  logic [31:0] obs_act[$];
  int          m_done;
  bit          m_to;
  int          m_idx[$];
  logic [31:0] m_act[$];

  typedef struct packed {
    logic [2:0]       n;
    logic [2:0][15:0] cyc;
    logic [2:0][4:0]  rd;
    logic [2:0][31:0] dat;
    logic [1:0]       nw;
    logic [2:0][7:0]  wt;
    logic [2:0][4:0]  wr;
    logic [2:0][31:0] wd;
    logic [7:0]       x_done;
    logic [3:0]       x_cnt;
    logic             x_pass;
    logic             x_to;
    logic [2:0]       x_eidx;
    logic [31:0]      x_eact;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_table();
    for (int i = 0; i < e_n; i++) begin
      chk_wr_en = 1'b1; chk_wr_idx = 3'(i); chk_wr_cycle = 16'(e_cyc[i]);
      chk_wr_rd = 5'(e_rd[i]); chk_wr_data = e_dat[i];
      tick();
    end
    chk_wr_en = 1'b0;
  endtask

  task automatic clear_trace();
    for (int t = 0; t < TL; t++) begin
      tr_en[t] = 1'b0; tr_rd[t] = '0; tr_dat[t] = '0; tr_pc[t] = 32'h1000 + 32'(4 * t);
    end
  endtask

  // Start a run, check the reset window, then drive the trace until done or a bound.
  task automatic run_once(input int inj_t, input int rst_t);
    bit fin;
    obs_idx.delete(); obs_act.delete(); obs_done_t = -1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i < RC; i++) tick();
    chk("cpu_reset_hold", cpu_reset, 1);
    tick();
    chk("cpu_reset_run", cpu_reset, 0);
    fin = 1'b0;
    for (int t = 0; t < TL && !fin; t++) begin
      wb_en = tr_en[t]; wb_rd = tr_rd[t]; wb_data = tr_dat[t]; pc = tr_pc[t];
      if (t == inj_t) begin
        chk_wr_en = 1'b1; chk_wr_idx = 3'(inj_idx); chk_wr_cycle = 16'(inj_cyc);
        chk_wr_rd = 5'(inj_rd); chk_wr_data = inj_dat;
      end
      if (t == rst_t) reset = 1'b1;
      tick();
      chk_wr_en = 1'b0;
      if (t == rst_t) begin
        reset = 1'b0;
        fin = 1'b1;
      end else begin
        if (err_valid) begin obs_idx.push_back(int'(err_idx)); obs_act.push_back(err_actual); end
        if (done) begin obs_done_t = t + 1; fin = 1'b1; end
      end
    end
    wb_en = 1'b0;
  endtask

  // Reference: walk run cycles, compare entries in order against a plain shadow array.
  task automatic model();
    logic [31:0] sh [32];
    int p, halt_t;
    for (int i = 0; i < 32; i++) sh[i] = '0;
    p = 0; m_done = -1; m_to = 1'b0; m_idx.delete(); m_act.delete();
    halt_t = -1;
`ifdef RV_CHECK_HALT_EN
    for (int t = 1; t < TL; t++) if (halt_t < 0 && tr_pc[t] == tr_pc[t-1]) halt_t = t;
`endif
    for (int t = 0; t < TO; t++) begin
      if (p < e_n && t >= e_cyc[p]) begin
        if (sh[e_rd[p]] != e_dat[p]) begin m_idx.push_back(p); m_act.push_back(sh[e_rd[p]]); end
        p++;
      end
      if (tr_en[t] && tr_rd[t] != 0) sh[tr_rd[t]] = tr_dat[t];
      if (p >= e_n) begin m_done = t + 1; break; end
      if (t == TO - 1) begin m_to = 1'b1; m_done = TO; break; end
      if (t == halt_t) begin
        m_done = t + 1 + (e_n - p);
        while (p < e_n) begin
          if (sh[e_rd[p]] != e_dat[p]) begin m_idx.push_back(p); m_act.push_back(sh[e_rd[p]]); end
          p++;
        end
        break;
      end
    end
  endtask

  task automatic check_vs_model(input string tag);
    int n;
    model();
    chk({tag, "_done_t"}, obs_done_t, m_done);
    chk({tag, "_timeout"}, timeout, m_to);
    chk({tag, "_err_count"}, err_count, m_idx.size());
    chk({tag, "_pass"}, pass, (m_idx.size() == 0 && !m_to) ? 1 : 0);
    chk({tag, "_nerr"}, obs_idx.size(), m_idx.size());
    n = (obs_idx.size() < m_idx.size()) ? obs_idx.size() : m_idx.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_err_idx"}, obs_idx[i], m_idx[i]);
      chk({tag, "_err_actual"}, obs_act[i], m_act[i]);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0; pc = '0;
    chk_wr_en = 1'b0; chk_wr_idx = '0; chk_wr_cycle = '0; chk_wr_rd = '0; chk_wr_data = '0;
    inj_idx = 0; inj_cyc = 0; inj_rd = 0; inj_dat = '0;

    // directed rows: {table, write-backs, expected done cycle/count/pass/timeout/first error}
    vt[0] = '{n:3, cyc:{16'd5, 16'd5, 16'd5}, rd:{5'd18, 5'd9, 5'd8}, dat:{32'h10, 32'd1, 32'd3},
              nw:3, wt:{8'd3, 8'd2, 8'd1}, wr:{5'd18, 5'd9, 5'd8}, wd:{32'h10, 32'd1, 32'd3},
              x_done:8, x_cnt:0, x_pass:1, x_to:0, x_eidx:0, x_eact:0};
    vt[1] = '{n:2, cyc:{16'd0, 16'd12, 16'd3}, rd:{5'd0, 5'd29, 5'd1}, dat:{32'd0, 32'hfffffffe, 32'd0},
              nw:1, wt:{8'd0, 8'd0, 8'd4}, wr:{5'd0, 5'd0, 5'd29}, wd:{32'd0, 32'd0, 32'hfffffffc},
              x_done:13, x_cnt:1, x_pass:0, x_to:0, x_eidx:1, x_eact:32'hfffffffc};
    vt[2] = '{n:1, cyc:{16'd0, 16'd0, 16'd5}, rd:{5'd0, 5'd0, 5'd5}, dat:{32'd0, 32'd0, 32'd3},
              nw:1, wt:{8'd0, 8'd0, 8'd5}, wr:{5'd0, 5'd0, 5'd5}, wd:{32'd0, 32'd0, 32'd3},
              x_done:6, x_cnt:1, x_pass:0, x_to:0, x_eidx:0, x_eact:0};
    vt[3] = '{n:1, cyc:{16'd0, 16'd0, 16'd100}, rd:{5'd0, 5'd0, 5'd1}, dat:'0,
              nw:0, wt:'0, wr:'0, wd:'0, x_done:64, x_cnt:0, x_pass:0, x_to:1, x_eidx:0, x_eact:0};
    vt[4] = '{n:0, cyc:'0, rd:'0, dat:'0, nw:0, wt:'0, wr:'0, wd:'0,
              x_done:1, x_cnt:0, x_pass:1, x_to:0, x_eidx:0, x_eact:0};
    vt[5] = '{n:1, cyc:{16'd0, 16'd0, 16'd2}, rd:'0, dat:'0,
              nw:1, wt:{8'd0, 8'd0, 8'd1}, wr:'0, wd:{32'd0, 32'd0, 32'd5},
              x_done:3, x_cnt:0, x_pass:1, x_to:0, x_eidx:0, x_eact:0};
    vt[6] = '{n:2, cyc:'0, rd:{5'd0, 5'd3, 5'd3}, dat:{32'd0, 32'd9, 32'd0},
              nw:1, wt:'0, wr:{5'd0, 5'd0, 5'd3}, wd:{32'd0, 32'd0, 32'd9},
              x_done:2, x_cnt:0, x_pass:1, x_to:0, x_eidx:0, x_eact:0};

    tick();
    do_reset();
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_idx", err_idx, 0);
    chk("rst_err_actual", err_actual, 0);
    chk("rst_err_count", err_count, 0);

    for (int r = 0; r < 7; r++) begin
      clear_trace();
      e_n = int'(vt[r].n);
      for (int i = 0; i < e_n; i++) begin
        e_cyc[i] = int'(vt[r].cyc[i]); e_rd[i] = int'(vt[r].rd[i]); e_dat[i] = vt[r].dat[i];
      end
      for (int i = 0; i < int'(vt[r].nw); i++) begin
        tr_en[vt[r].wt[i]] = 1'b1; tr_rd[vt[r].wt[i]] = vt[r].wr[i]; tr_dat[vt[r].wt[i]] = vt[r].wd[i];
      end
      do_reset(); load_table(); run_once(-1, -1);
      chk($sformatf("row%0d_done_t", r), obs_done_t, vt[r].x_done);
      chk($sformatf("row%0d_err_count", r), err_count, vt[r].x_cnt);
      chk($sformatf("row%0d_pass", r), pass, vt[r].x_pass);
      chk($sformatf("row%0d_timeout", r), timeout, vt[r].x_to);
      chk($sformatf("row%0d_nerr", r), obs_idx.size(), vt[r].x_cnt);
      if (obs_idx.size() > 0 && vt[r].x_cnt > 0) begin
        chk($sformatf("row%0d_err_idx", r), obs_idx[0], vt[r].x_eidx);
        chk($sformatf("row%0d_err_actual", r), obs_act[0], vt[r].x_eact);
      end
    end

    // table write while busy must be ignored
    clear_trace();
    e_n = 2; e_cyc[0] = 5; e_rd[0] = 8; e_dat[0] = 3; e_cyc[1] = 6; e_rd[1] = 8; e_dat[1] = 3;
    tr_en[1] = 1'b1; tr_rd[1] = 5'd8; tr_dat[1] = 32'd3;
    inj_idx = 1; inj_cyc = 6; inj_rd = 8; inj_dat = 32'd7;
    do_reset(); load_table(); run_once(3, -1);
    chk("busywr_done_t", obs_done_t, 7);
    chk("busywr_pass", pass, 1);
    chk("busywr_err_count", err_count, 0);

    // reset mid-run returns to IDLE and invalidates the table
    clear_trace();
    e_n = 1; e_cyc[0] = 20; e_rd[0] = 1; e_dat[0] = 32'd5;
    inj_idx = 0; inj_cyc = 30; inj_rd = 2; inj_dat = 32'd1;
    do_reset(); load_table(); run_once(3, 7);
    chk("midrst_busy", busy, 0);
    chk("midrst_cpu_reset", cpu_reset, 1);
    chk("midrst_done", done, 0);
    chk("midrst_err_count", err_count, 0);
    e_n = 0;
    run_once(-1, -1);
    check_vs_model("midrst_empty");
    chk("midrst_empty_done_t", obs_done_t, 1);

`ifdef RV_CHECK_HALT_EN
    clear_trace();
    for (int t = 20; t < TL; t++) tr_pc[t] = 32'h40;
    e_n = 2; e_cyc[0] = 500; e_rd[0] = 1; e_dat[0] = 0; e_cyc[1] = 600; e_rd[1] = 2; e_dat[1] = 0;
    do_reset(); load_table(); run_once(-1, -1);
    chk("halt_done_t", obs_done_t, 24);
    chk("halt_pass", pass, 1);
    check_vs_model("halt");
`endif

    for (int r = 0; r < 24; r++) begin
      int c, hf;
      clear_trace();
      e_n = $urandom_range(0, 8);
      c = $urandom_range(0, 4) + (($urandom_range(0, 7) == 0) ? 40 : 0);
      for (int i = 0; i < e_n; i++) begin
        c += $urandom_range(0, 6);
        e_cyc[i] = c; e_rd[i] = $urandom_range(0, 3); e_dat[i] = 32'($urandom_range(0, 3));
      end
      hf = ($urandom_range(0, 1) == 1) ? $urandom_range(5, 40) : TL;
      for (int t = 0; t < TL; t++) begin
        tr_en[t] = 1'($urandom_range(0, 1)); tr_rd[t] = 5'($urandom_range(0, 3));
        tr_dat[t] = 32'($urandom_range(0, 3));
        if (t >= hf) tr_pc[t] = 32'h2000;
      end
      do_reset(); load_table(); run_once(-1, -1);
      check_vs_model($sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv_check_sequencer.md
# rv_check_sequencer

Synthesizable self-checking harness for the single-cycle RV32I core. It holds the core in reset for a programmable number of cycles, then releases it. It snoops register write-back into a shadow register file and compares that file against a preloaded table of (cycle, register, expected value) checkpoints. It reports per-check errors and a final pass/fail, and is parametrised in data width, register count, checkpoint depth and timeout. It sits beside the `rv32i` core in the top-level test wrapper, replacing hand-timed testbench checks.

## Interface
Parameters:
- `XLEN`, 32: data width of the register file and of expected values.
- `NREG`, 32: number of architectural registers; index width `RW = $clog2(NREG)`.
- `NCHK`, 8: checkpoint table depth; index width `IW = $clog2(NCHK)`.
- `CW`, 16: run-cycle counter width.
- `RST_CYCLES`, 10: number of cycles `cpu_reset` is held in HOLD.
- `TIMEOUT`, 1024: maximum number of RUN cycles.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request to begin a run; accepted only in IDLE or DONE.
- `cpu_reset` out 1: reset driven to the core.
- `wb_en`, `wb_rd`[RW], `wb_data`[XLEN] in: the core's write-back (regWrite, rd, result).
- `pc` in XLEN: the core's program counter.
- `chk_wr_en`, `chk_wr_idx`[IW], `chk_wr_cycle`[CW], `chk_wr_rd`[RW], `chk_wr_data`[XLEN] in: table load port.
- `busy` out 1: asserted in HOLD, RUN or DRAIN.
- `done` out 1: asserted in DONE.
- `pass` out 1: valid while `done`.
- `timeout` out 1: valid while `done`.
- `err_valid` out 1: one-cycle pulse per failed check.
- `err_idx` out IW: index of the failed entry.
- `err_actual` out XLEN: shadow value at compare time.
- `err_count` out `$clog2(NCHK+1)`: number of failed checks.

## Operation
- States:
  - IDLE → HOLD on `start`.
  - HOLD → RUN after RST_CYCLES cycles.
  - RUN → DONE when no pending valid entry remains, or on timeout.
  - RUN → DRAIN on halt (macro only).
  - DRAIN → DONE when no pending valid entry remains.
  - DONE → HOLD on `start`.
- HOLD entry:
  - clears the shadow file, pointer `ptr`, `err_count`, the run counter and `timeout`;
  - `cpu_reset`=1 throughout HOLD, 0 in RUN/DRAIN/DONE/IDLE after the first start.
- Table:
  - per entry: valid bit, cycle, rd, data;
  - `chk_wr_en` writes the entry and sets its valid bit only when `busy`=0; writes while busy are ignored;
  - `reset` clears all valid bits.
- Shadow file: updated on `wb_en` in RUN only; writes with `wb_rd`=0 are ignored, so register 0 always reads 0.
- Checks:
  - entries are processed strictly in index order from 0;
  - an entry is compared when `run_cycle >= cycle[ptr]`; at most one compare per clock;
  - after each compare, `ptr` increments;
  - the first invalid entry or `ptr`=NCHK ends the check list.
- Compare reads the shadow value as of the start of the cycle. A write-back to the same register in the same cycle is not seen.
- Mismatch: `err_valid`, `err_idx`, `err_actual` are registered; `err_count` increments.
- Timeout: `run_cycle` = TIMEOUT-1 with a pending entry → DONE, `timeout`=1.
- `pass` = (`err_count`==0) && !`timeout`.
- `start` in HOLD/RUN/DRAIN is ignored.

## Timing
- Reset values:
  - state IDLE, `cpu_reset`=1;
  - `busy`, `done`, `pass`, `timeout`, `err_valid` = 0;
  - `err_idx`, `err_actual`, `err_count` = 0.
- `start` at edge N → HOLD in cycle N+1; `cpu_reset` falls exactly RST_CYCLES cycles later.
- `run_cycle` = 0 in the first RUN cycle.
- Error latency: 1 cycle from the compare cycle to `err_valid`.
- `done` rises the cycle after the last compare, so the final `err_valid` and `done` coincide.
- `reset` mid-run: immediate return to IDLE with `cpu_reset`=1; the table is invalidated.

## Configuration
- `RV_CHECK_HALT_EN`:
  - Defined: in RUN, `pc` unchanged for two consecutive cycles means the core has halted (jump-to-self). The block enters DRAIN, where the remaining entries are compared one per clock regardless of their cycle field, then goes to DONE.
  - Undefined: no halt detection. Pending entries wait until their cycle or until timeout.

## Structure
- Package `rv_check_pkg`: state enum (IDLE, HOLD, RUN, DRAIN, DONE) and the checkpoint entry struct (valid, cycle, rd, data).
- Sub-module `rv_shadow_regfile`: NREG×XLEN, one write port, one combinational read port, synchronous clear, register 0 hardwired to zero.

## Test plan
- Table {0: cyc 5, x8=3; 1: cyc 5, x9=1; 2: cyc 5, x18=0x10}, core matches → `done`, `pass`=1, `err_count`=0.
- Entry {cyc 12, x29=0xfffffffe}, core writes 0xfffffffc → `err_valid` with `err_idx`=k, `err_actual`=0xfffffffc; `pass`=0.
- Write-back x5=3 in the same cycle as a check of x5=3, previous value 0 → mismatch with `err_actual`=0.
- TIMEOUT=64 with entry cycle 100 → `done` at run cycle 64, `timeout`=1, `pass`=0.
- With `RV_CHECK_HALT_EN`, core loops at pc 0x40 from cycle 20 with entries at cycles 500 and 600 → DRAIN compares both in consecutive cycles, then DONE.
- `chk_wr_en` during RUN, and `reset` at run cycle 7 → table unchanged by the write, then IDLE with `cpu_reset`=1 and all entries invalid.
